// File: rtl/daq_sample_fifo_slave_if.sv
// Wishbone B3 bus bundle between the DAQ master and the sample FIFO responder.
// The signal names follow the responder's view, so the _i and _o suffixes are relative to the slave.
interface daq_sample_fifo_slave_if #(
  parameter int dw = 32,
  parameter int aw = 32
);
  logic [aw-1:0] wb_adr_i;
  logic [dw-1:0] wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [2:0]    wb_cti_i;
  logic [1:0]    wb_bte_i;
  logic [dw-1:0] wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/daq_sample_fifo_slave.sv
// Wishbone B3 responder that sinks and sources 32-bit DAQ samples through a small FIFO.
// It also provides status, control and threshold registers and a level interrupt.
module daq_sample_fifo_slave #(
  parameter int            dw       = 32,
  parameter int            aw       = 32,
  parameter int            FIFO_AW  = 4,
  parameter logic [aw-1:0] BASE_ADR = '0
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  daq_sample_fifo_slave_if.slave wb,
  output logic                   irq,
  output logic [FIFO_AW:0]       fifo_count
);

  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_THRESH  = 2'd3;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_ERR
  } state_t;

  state_t state, state_next;

  logic [dw-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   thresh;
  logic               overflow, underflow;
  logic               last_burst;
  logic [dw-1:0]      dat_q;

  logic               req, in_window, bad_beat, burst_cont, accept, good;
  logic [1:0]         reg_sel;
  logic               do_push, do_pop, do_ctrl, do_thresh;
  logic               full, empty;
  logic [dw-1:0]      status_word, rd_data;
  logic [1:0]         unused_adr_bits;

  assign full  = count[FIFO_AW];
  assign empty = (count == '0);

  assign unused_adr_bits = wb.wb_adr_i[1:0];

  // A beat is taken either from idle or as the next beat of an incrementing burst while ack is still high.
  // The end-of-burst beat (cti=111) is also taken back-to-back, so the burst has no gap before ack drops.
  always_comb begin
    state_next  = ST_IDLE;
    req         = wb.wb_cyc_i & wb.wb_stb_i;
    in_window   = (wb.wb_adr_i[aw-1:4] == BASE_ADR[aw-1:4]);
    reg_sel     = wb.wb_adr_i[3:2];
    bad_beat    = !in_window
                | ((reg_sel == REG_DATA) && (wb.wb_sel_i != 4'hF))
                | ((reg_sel == REG_STATUS) && wb.wb_we_i);
    burst_cont  = (state == ST_ACK) && req && last_burst && (wb.wb_bte_i == 2'b00)
                && ((wb.wb_cti_i == CTI_INCR) || (wb.wb_cti_i == CTI_EOB));
    accept      = (req && (state == ST_IDLE)) || burst_cont;
    good        = accept && !bad_beat;
    do_push     = good && wb.wb_we_i && (reg_sel == REG_DATA);
    do_pop      = good && !wb.wb_we_i && (reg_sel == REG_DATA);
    do_ctrl     = good && wb.wb_we_i && (reg_sel == REG_CONTROL);
    do_thresh   = good && wb.wb_we_i && (reg_sel == REG_THRESH);
    if (accept) begin
      state_next = bad_beat ? ST_ERR : ST_ACK;
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    status_word              = '0;
    status_word[FIFO_AW:0]   = count;
    status_word[8]           = empty;
    status_word[9]           = full;
    status_word[16]          = overflow;
    status_word[17]          = underflow;

    rd_data = '0;
    if (!wb.wb_we_i) begin
      case (reg_sel)
        REG_DATA:   rd_data = empty ? '0 : mem[rd_ptr];
        REG_STATUS: rd_data = status_word;
        REG_THRESH: rd_data[FIFO_AW:0] = thresh;
        default:    rd_data = '0;
      endcase
    end
  end

  // FIFO bookkeeping, register writes and the registered read data all change at the edge that accepts the beat.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      thresh     <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      last_burst <= 1'b0;
      dat_q      <= '0;
      irq        <= 1'b0;
    end else begin
      irq   <= (thresh != '0) && (count >= thresh);
      dat_q <= good ? rd_data : '0;

      if (accept) begin
        last_burst <= (wb.wb_cti_i == CTI_INCR) && (wb.wb_bte_i == 2'b00);
      end

      if (do_push) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 1'b1;
        end
      end

      if (do_pop) begin
        if (empty) begin
          underflow <= 1'b1;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
          count  <= count - 1'b1;
        end
      end

      if (do_ctrl) begin
        if (wb.wb_dat_i[0]) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end
        if (wb.wb_dat_i[1]) begin
          overflow  <= 1'b0;
          underflow <= 1'b0;
        end
      end

      if (do_thresh) begin
        thresh <= wb.wb_dat_i[FIFO_AW:0];
      end
    end
  end

  // Sample storage has no reset; a flush only rewinds the pointers.
  always_ff @(posedge wb_clk) begin
    if (do_push && !full) begin
      mem[wr_ptr] <= wb.wb_dat_i;
    end
  end

  assign wb.wb_ack_o = (state == ST_ACK);
  assign wb.wb_err_o = (state == ST_ERR);
  assign wb.wb_rty_o = 1'b0;
  assign wb.wb_dat_o = dat_q;
  assign fifo_count  = count;

endmodule

// File: doc/daq_sample_fifo_slave.md
Name: daq_sample_fifo_slave

Overview:
Wishbone B3 responder that terminates the transactions issued by the DAQ Wishbone master. It is used as the sample sink/source for DAQ bench and loopback testing. Master writes to the DATA register push 32-bit samples into an internal FIFO, and reads of DATA pop them. Status, control and threshold registers give software visibility and a level interrupt. Supports classic single cycles and incrementing bursts (cti=3'b010).

Parameters:
dw, 32, data bus width (only 32 supported)
aw, 32, address bus width
FIFO_AW, 4, log2 of FIFO depth (depth = 16)
BASE_ADR, 32'h0000_0000, base of the 16-byte register window; wb_adr_i[aw-1:4] is compared with BASE_ADR[aw-1:4]

Ports:
wb_clk  in  1  clock
wb_rst  in  1  reset
wb_adr_i  in  aw  byte address; bits [3:2] select the register
wb_dat_i  in  dw  write data
wb_sel_i  in  4  byte selects
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_cti_i  in  3  cycle type identifier
wb_bte_i  in  2  burst type extension
wb_dat_o  out  dw  read data, valid while ack is high
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination
wb_rty_o  out  1  retry; tied to 0
irq  out  1  level interrupt
fifo_count  out  FIFO_AW+1  current occupancy, 0..16

Behaviour:
- Reset and clocking: one clock, wb_clk. wb_rst is asynchronous and active-high.
- Reset values: ack=0, err=0, dat_o=0, irq=0, count=0, FIFO pointers=0, sticky flags=0, THRESHOLD=0.
- Register map:
  - 0x0 DATA: write pushes, read pops.
  - 0x4 STATUS (RO): [4:0]=count, [8]=empty, [9]=full, [16]=overflow (sticky), [17]=underflow (sticky).
  - 0x8 CONTROL (WO, reads 0): bit0=flush, bit1=clear sticky flags. Both self-clear and act in the acceptance cycle.
  - 0xC THRESHOLD (RW): [4:0]; upper bits read 0.
- Acceptance: a beat is accepted in cycle N when cyc & stb & !(ack|err), or when it qualifies as a burst continuation (below).
  - ack or err is registered and asserted in N+1.
  - dat_o is registered with ack.
  - Side effects (push, pop, register write) occur at the clock edge ending cycle N.
- Classic cycle: ack is high for exactly one cycle. The earliest next acceptance is the cycle after ack falls, so each transfer takes at least 2 cycles.
- Burst continuation: if ack=1 and cyc & stb & cti==3'b010 & bte==2'b00 hold in cycle N, that beat is accepted and ack stays high in N+1.
  - The address is taken from wb_adr_i on every beat; the slave does not increment it internally.
  - cti==3'b111 (end of burst) is accepted normally; ack drops after that beat.
  - Any bte other than 00 during a burst: the beat is accepted as a classic cycle.
- Error conditions: err is asserted instead of ack when any of these holds:
  - the address is outside the window;
  - the access is to DATA with sel != 4'hF;
  - the access is a write to STATUS.
  - Error beats cause no side effects.
- Push when full: data is dropped, overflow is set, ack is still returned.
- Pop when empty: dat_o=0, underflow is set, ack is returned.
- Flush: count, read pointer and write pointer are cleared to 0 on the edge. Stored data is not cleared.
- Simultaneous events:
  - The bus performs at most one push or pop per cycle, so there is no simultaneous push and pop.
  - Flush and clear-sticky written together both take effect.
  - A push/pop flag event in the same cycle as a clear-sticky write is impossible (single port).
- Pointers wrap modulo 2^FIFO_AW. full = (count==16), empty = (count==0).
- irq = (THRESHOLD != 0) && (count >= THRESHOLD), registered. It updates one cycle after count changes.
- Dropped cycles: if cyc falls while ack is pending, ack still pulses for one cycle and the side effect stands. The master ignores it.
- Reset mid-burst: ack/err drop asynchronously and the FIFO is emptied.

Test Plan:
- Classic write of 0xA5A5_0001 to 0x0, then read of 0x4 -> ack one cycle after stb; STATUS = 0x0000_0001 (count=1, empty=0).
- 16 pushes of 0..15, then a 17th push of 0xDEAD -> 17th beat acked; STATUS full=1, overflow=1, count=16; popping 16 times returns 0..15 in order, then STATUS empty=1.
- Read DATA when empty -> dat_o=0, ack=1, STATUS bit17=1; write 0x2 to CONTROL -> STATUS bit17=0.
- Burst of 4 writes (cti 010,010,010,111) to 0x0 -> ack continuously high for 4 cycles; count=4, no gap between beats.
- Access to 0x10 with BASE=0, a sel=4'h3 access to DATA, and a write to STATUS -> err=1, ack=0, count unchanged.
- THRESHOLD=3: push 2 (irq=0), push 1 more (irq=1 the cycle after ack), write 0x1 to CONTROL -> count=0, irq=0. Assert wb_rst mid-burst -> ack drops immediately, count=0.
